// File: rtl/cash_accumulator.sv
// Cash accumulator: counts note pulses per channel and sums their value until a target is met.
// Define CASH_ACCUMULATOR_SYNC_EN to pass each pulse bit through a 2-flop synchronizer first.
module cash_accumulator #(
  parameter int                   NUM_CH = 3,
  parameter int                   CW     = 9,
  parameter int                   AW     = 19,
  parameter logic [NUM_CH*AW-1:0] DENOMS = {19'd5000, 19'd2000, 19'd1000}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        target,
  input  logic [NUM_CH-1:0]    pulse,
  input  logic                 ack,
  output logic                 out,
  output logic                 busy,
  output logic [AW-1:0]        total,
  output logic [AW-1:0]        change,
  output logic [NUM_CH*CW-1:0] counts,
  output logic                 sat
);
  // Four guard bits cover the current total plus up to eight maximal denominations.
  localparam int            SW        = AW + 4;
  localparam logic [AW-1:0] TOTAL_MAX = {AW{1'b1}};
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_out;
  logic                 r_busy;
  logic                 r_sat;
  logic [AW-1:0]        r_total;
  logic [AW-1:0]        r_target;
  logic [AW-1:0]        r_change;
  logic [NUM_CH*CW-1:0] r_counts;
  logic [NUM_CH-1:0]    r_prev;

  logic [NUM_CH-1:0]    w_pulse;
  logic [NUM_CH-1:0]    w_edge;
  logic [NUM_CH-1:0]    w_cnt_ovf;
  logic [SW-1:0]        w_sum;
  logic [AW-1:0]        w_total_nxt;
  logic                 w_tot_ovf;
  logic [NUM_CH*CW-1:0] w_counts_nxt;

`ifdef CASH_ACCUMULATOR_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  // Two-stage synchronizer on the asynchronous note pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= {NUM_CH{1'b0}};
      r_sync2 <= {NUM_CH{1'b0}};
    end else begin
      r_sync1 <= pulse;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pulse = r_sync2;
`else
  assign w_pulse = pulse;
`endif

  // Sum the denominations of every edge seen this cycle, clamped to the total range.
  always_comb begin
    w_edge = w_pulse & ~r_prev;
    w_sum  = SW'(r_total);
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = w_sum + (w_edge[i] ? SW'(DENOMS[i*AW +: AW]) : {SW{1'b0}});
    end
    w_tot_ovf   = (w_sum > SW'(TOTAL_MAX));
    w_total_nxt = w_tot_ovf ? TOTAL_MAX : w_sum[AW-1:0];
  end

  // Per-channel counters hold at their ceiling and flag the dropped note.
  always_comb begin
    w_counts_nxt = r_counts;
    w_cnt_ovf    = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_edge[i] && (r_counts[i*CW +: CW] == COUNT_MAX)) begin
        w_cnt_ovf[i] = 1'b1;
      end else if (w_edge[i]) begin
        w_counts_nxt[i*CW +: CW] = r_counts[i*CW +: CW] + CW'(1'b1);
      end else begin
        w_counts_nxt[i*CW +: CW] = r_counts[i*CW +: CW];
      end
    end
  end

  // Transaction FSM with its registered outputs; start overrides ack and pulse edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_sat    <= 1'b0;
      r_total  <= {AW{1'b0}};
      r_target <= {AW{1'b0}};
      r_change <= {AW{1'b0}};
      r_counts <= {(NUM_CH*CW){1'b0}};
      r_prev   <= {NUM_CH{1'b0}};
    end else begin
      r_prev <= w_pulse;
      if (start) begin
        r_state  <= S_COLLECT;
        r_out    <= 1'b0;
        r_busy   <= 1'b1;
        r_sat    <= 1'b0;
        r_total  <= {AW{1'b0}};
        r_target <= target;
        r_change <= {AW{1'b0}};
        r_counts <= {(NUM_CH*CW){1'b0}};
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_COLLECT: begin
            r_total  <= w_total_nxt;
            r_counts <= w_counts_nxt;
            r_sat    <= r_sat | w_tot_ovf | (|w_cnt_ovf);
            // Completion looks at the already-registered total, so it trails the last note by a cycle.
            if (r_total >= r_target) begin
              r_state  <= S_DONE;
              r_out    <= 1'b1;
              r_busy   <= 1'b0;
              r_change <= w_total_nxt - r_target;
            end else begin
              r_state <= S_COLLECT;
            end
          end
          S_DONE: begin
            if (ack) begin
              r_state  <= S_IDLE;
              r_out    <= 1'b0;
              r_change <= {AW{1'b0}};
            end else begin
              r_state <= S_DONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out    = r_out;
  assign busy   = r_busy;
  assign total  = r_total;
  assign change = r_change;
  assign counts = r_counts;
  assign sat    = r_sat;

endmodule
